// File: rtl/l1i_cache_ctrl.sv
// -----------------------------------------------------------------------------
// l1i_cache_ctrl
// Direct-mapped, read-only L1 instruction cache controller:
// 32 lines x 64 B, 21-bit tags. It answers core reads in the same cycle on a hit.
// On a miss it stalls the core and fetches the whole 512-bit line from L2.
// It then writes the line and lets the held request complete as a hit.
//
// Optional build macro: L1I_PERF_CNT_EN adds hit_cnt / miss_cnt outputs.
//
// Ports
//   clk               clock, all state changes on the rising edge
//   nrst              synchronous active-high reset
//   read_C_L1I        core read strobe (held while stall_L1I is high)
//   tag_C_L1          request tag
//   index_C_L1        request line index
//   offset            byte offset, [5:2] selects the word
//   flush_L1I         invalidate all lines (honoured only when idle)
//   stall_L1I         core must hold its request
//   read_data_L1I_C   instruction word (0 unless a hit is served)
//   read_L1I_L2       line fetch request to L2
//   tag_L1I_L2        latched fetch tag
//   index_L1I_L2      latched fetch index
//   ready_L2_L1I      L2 line valid this cycle
//   read_data_L2_L1I  fill line, word w at bits [32w+31:32w]
//   hit_cnt/miss_cnt  performance counters (L1I_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module l1i_cache_ctrl #(
  parameter int TAG_W    = 21,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 6,
  parameter int WORD_W   = 32
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          read_C_L1I,
  input  logic [TAG_W-1:0]              tag_C_L1,
  input  logic [INDEX_W-1:0]            index_C_L1,
  input  logic [OFFSET_W-1:0]           offset,
  input  logic                          flush_L1I,
  output logic                          stall_L1I,
  output logic [WORD_W-1:0]             read_data_L1I_C,
  output logic                          read_L1I_L2,
  output logic [TAG_W-1:0]              tag_L1I_L2,
  output logic [INDEX_W-1:0]            index_L1I_L2,
  input  logic                          ready_L2_L1I,
  input  logic [(2**OFFSET_W)*8-1:0]    read_data_L2_L1I
`ifdef L1I_PERF_CNT_EN
  ,
  output logic [31:0]                   hit_cnt,
  output logic [31:0]                   miss_cnt
`endif
);

  localparam int LINES    = 2**INDEX_W;
  localparam int LINE_W   = (2**OFFSET_W)*8;
  localparam int WORD_LSB = $clog2(WORD_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALLOC = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [LINE_W-1:0]    r_data [LINES];
  logic [TAG_W-1:0]     r_tag  [LINES];
  logic [LINES-1:0]     r_valid;
  logic [LINE_W-1:0]    r_line_buf;
  logic [TAG_W-1:0]     r_l2_tag;
  logic [INDEX_W-1:0]   r_l2_idx;

  logic                 w_hit;
  logic [LINE_W-1:0]    w_line;
  logic [OFFSET_W-3:0]  w_word_sel;
  logic [WORD_W-1:0]    w_hit_word;
  logic                 w_miss_start;
  logic                 w_flush;
  logic                 w_capture;
  logic                 w_fill_we;
  logic                 w_unused;

  // Byte-within-word offset bits play no role in an instruction-word fetch.
  assign w_unused   = ^offset[1:0];

  assign w_hit      = read_C_L1I & r_valid[index_C_L1] & (r_tag[index_C_L1] == tag_C_L1);
  assign w_line     = r_data[index_C_L1];
  assign w_word_sel = offset[OFFSET_W-1:2];
  assign w_hit_word = w_line[{w_word_sel, {WORD_LSB{1'b0}}} +: WORD_W];

  assign tag_L1I_L2   = r_l2_tag;
  assign index_L1I_L2 = r_l2_idx;

  // Next-state and output decode; flush wins over a read in the same idle cycle
  always_comb begin
    w_state_nxt     = r_state;
    stall_L1I       = 1'b0;
    read_data_L1I_C = {WORD_W{1'b0}};
    read_L1I_L2     = 1'b0;
    w_miss_start    = 1'b0;
    w_flush         = 1'b0;
    w_capture       = 1'b0;
    w_fill_we       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (flush_L1I) begin
          w_flush   = 1'b1;
          stall_L1I = 1'b1;
        end else if (w_hit) begin
          read_data_L1I_C = w_hit_word;
        end else if (read_C_L1I) begin
          stall_L1I    = 1'b1;
          w_miss_start = 1'b1;
          w_state_nxt  = ST_ALLOC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ALLOC: begin
        stall_L1I   = 1'b1;
        read_L1I_L2 = 1'b1;
        if (ready_L2_L1I) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_FILL;
        end else begin
          w_state_nxt = ST_ALLOC;
        end
      end
      ST_FILL: begin
        stall_L1I   = 1'b1;
        w_fill_we   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Valid bits: cleared by reset or flush, set when a line is filled
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_valid <= {LINES{1'b0}};
    end else if (w_flush) begin
      r_valid <= {LINES{1'b0}};
    end else if (w_fill_we) begin
      r_valid[r_l2_idx] <= 1'b1;
    end
  end

  // L2 address registers: latched on the miss cycle, stable through the fetch
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_l2_tag <= {TAG_W{1'b0}};
      r_l2_idx <= {INDEX_W{1'b0}};
    end else if (w_miss_start) begin
      r_l2_tag <= tag_C_L1;
      r_l2_idx <= index_C_L1;
    end
  end

  // Line storage: buffer the L2 line, then commit data and tag during FILL.
  // A reset landing on the FILL edge suppresses the write.
  always_ff @(posedge clk) begin
    if (w_capture && !nrst) begin
      r_line_buf <= read_data_L2_L1I;
    end
    if (w_fill_we && !nrst) begin
      r_data[r_l2_idx] <= r_line_buf;
      r_tag[r_l2_idx]  <= r_l2_tag;
    end
  end

`ifdef L1I_PERF_CNT_EN
  logic        w_hit_served;
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  assign w_hit_served = (r_state == ST_IDLE) & ~flush_L1I & w_hit;

  // Performance counters: served hits and miss starts, wrapping at 2**32
  always_ff @(posedge clk) begin
    if (nrst) begin
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else begin
      if (w_hit_served) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_miss_start) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_l1i_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_l1i_cache_ctrl
// Self-checking bench for l1i_cache_ctrl. A behavioural cache model in the
// bench predicts every output on every cycle. The model covers valid/tag/data
// arrays, an outstanding-fetch record and an L2 responder. Directed sequences
// pin latencies and data with literal values. Define L1I_PERF_CNT_EN to also
// check the counters.
// -----------------------------------------------------------------------------
module tb_l1i_cache_ctrl;

  logic         clk = 1'b0;
  logic         nrst;
  logic         read;
  logic         flush;
  logic         ready;
  logic [20:0]  tag;
  logic [4:0]   idx;
  logic [5:0]   off;
  logic [511:0] l2_data;
  logic         stall;
  logic         req;
  logic [31:0]  rdata;
  logic [20:0]  l2_tag;
  logic [4:0]   l2_idx;
`ifdef L1I_PERF_CNT_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  always #5 clk = ~clk;

  l1i_cache_ctrl dut (
    .clk              (clk),
    .nrst             (nrst),
    .read_C_L1I       (read),
    .tag_C_L1         (tag),
    .index_C_L1       (idx),
    .offset           (off),
    .flush_L1I        (flush),
    .stall_L1I        (stall),
    .read_data_L1I_C  (rdata),
    .read_L1I_L2      (req),
    .tag_L1I_L2       (l2_tag),
    .index_L1I_L2     (l2_idx),
    .ready_L2_L1I     (ready),
    .read_data_L2_L1I (l2_data)
`ifdef L1I_PERF_CNT_EN
    ,
    .hit_cnt          (hit_cnt),
    .miss_cnt         (miss_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: cache contents plus "a fetch is outstanding" and
  // "the line has arrived and is about to be written".
  bit           m_init = 1'b0;
  bit           m_busy = 1'b0;
  bit           m_have = 1'b0;
  bit           m_valid [32];
  logic [20:0]  m_tag   [32];
  logic [31:0]  m_data  [32][16];
  logic [20:0]  m_ltag;
  logic [4:0]   m_lidx;
  logic [511:0] m_buf;
  int unsigned  m_hits   = 0;
  int unsigned  m_misses = 0;

  // L2 responder controls
  int req_age     = 0;
  int wait_n      = 3;
  bit rand_wait   = 1'b0;
  bit force_ready = 1'b0;

  // Outputs sampled in the most recent cycle
  logic        s_stall;
  logic        s_req;
  logic [31:0] s_data;
  logic [20:0] s_tag;
  logic [4:0]  s_idx;

  // L2 backing store: tag 0 / index 1 yields 0x1000_0000 + w
  function automatic logic [31:0] l2_word(input logic [20:0] t, input logic [4:0] i, input int w);
    logic [31:0] key;
    key = {t[15:0], i ^ 5'd1, 11'd0};
    return (32'h1000_0000 + 32'(w)) ^ key;
  endfunction

  function automatic logic [511:0] l2_line(input logic [20:0] t, input logic [4:0] i);
    logic [511:0] l;
    for (int w = 0; w < 16; w++) l[32*w +: 32] = l2_word(t, i, w);
    return l;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int w = 0; w < 16; w++) l[32*w +: 32] = $urandom;
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs of this cycle
  task automatic model_update();
    bit hit;
    if (nrst) begin
      m_init = 1'b1; m_busy = 1'b0; m_have = 1'b0;
      for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
      m_ltag = 21'd0; m_lidx = 5'd0; m_hits = 0; m_misses = 0;
    end else if (m_init) begin
      hit = read && m_valid[idx] && (m_tag[idx] == tag);
      if (!m_busy) begin
        if (flush) begin
          for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
        end else if (hit) begin
          m_hits++;
        end else if (read) begin
          m_busy = 1'b1; m_have = 1'b0; m_ltag = tag; m_lidx = idx; m_misses++;
        end
      end else if (!m_have) begin
        if (ready) begin
          m_have = 1'b1; m_buf = l2_data;
        end
      end else begin
        for (int w = 0; w < 16; w++) m_data[m_lidx][w] = m_buf[32*w +: 32];
        m_tag[m_lidx] = m_ltag; m_valid[m_lidx] = 1'b1;
        m_busy = 1'b0; m_have = 1'b0;
      end
    end
  endtask

  // One clock cycle: drive L2, compare all outputs with the model, clock it
  task automatic tick();
    logic        e_stall, e_req;
    logic [31:0] e_data;
    if (m_init && m_busy && !m_have) begin
      req_age++;
      if (req_age == 1 && rand_wait) wait_n = $urandom_range(1, 4);
      ready   = (req_age == wait_n);
      l2_data = l2_line(m_ltag, m_lidx);
    end else begin
      req_age = 0;
      ready   = force_ready | ($urandom_range(0, 3) == 0);
      l2_data = rand_line();
    end
    #2;
    s_stall = stall; s_req = req; s_data = rdata; s_tag = l2_tag; s_idx = l2_idx;
    if (m_init) begin
      e_stall = 1'b0; e_req = 1'b0; e_data = 32'd0;
      if (m_busy) begin
        e_stall = 1'b1;
        e_req   = !m_have;
      end else if (flush) begin
        e_stall = 1'b1;
      end else if (read && m_valid[idx] && m_tag[idx] == tag) begin
        e_data = m_data[idx][off[5:2]];
      end else if (read) begin
        e_stall = 1'b1;
      end
      chk("stall", 32'(s_stall), 32'(e_stall));
      chk("read_data", s_data, e_data);
      chk("l2_req", 32'(s_req), 32'(e_req));
      chk("l2_tag", 32'(s_tag), 32'(m_ltag));
      chk("l2_index", 32'(s_idx), 32'(m_lidx));
`ifdef L1I_PERF_CNT_EN
      chk("hit_cnt", hit_cnt, m_hits);
      chk("miss_cnt", miss_cnt, m_misses);
`endif
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // Hold a read until the stall drops; report stall cycles, data and fetch address
  task automatic do_read(input logic [20:0] t, input logic [4:0] i, input logic [5:0] o,
                         output int stalls, output logic [31:0] d,
                         output logic [20:0] rt, output logic [4:0] ri);
    bit done;
    read = 1'b1; tag = t; idx = i; off = o;
    stalls = 0; d = 32'hDEAD_BEEF; rt = 21'h1F_FFFF; ri = 5'h1F; done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (s_req) begin rt = s_tag; ri = s_idx; end
      if (!s_stall) begin d = s_data; done = 1'b1; break; end
      stalls++;
    end
    read = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL read_timeout: stall still high after %0d cycles", stalls);
    end
  endtask

  initial begin
    int          st;
    logic [31:0] d;
    logic [20:0] rt;
    logic [4:0]  ri;

    nrst = 1'b1; read = 1'b0; flush = 1'b0; ready = 1'b0;
    tag = 21'd0; idx = 5'd0; off = 6'd0; l2_data = 512'd0;

    // Reset and idle outputs
    tick(); tick();
    nrst = 1'b0;
    tick();
    chk("rst_stall", 32'(s_stall), 32'd0);
    chk("rst_req", 32'(s_req), 32'd0);
    chk("rst_data", s_data, 32'd0);
    chk("rst_l2_tag", 32'(s_tag), 32'd0);
    chk("rst_l2_idx", 32'(s_idx), 32'd0);

    // Cold miss: ready on the third request cycle gives a 5-cycle stall
    wait_n = 3;
    do_read(21'd0, 5'd1, 6'h04, st, d, rt, ri);
    chk("miss1_stalls", 32'(st), 32'd5);
    chk("miss1_l2_tag", 32'(rt), 32'd0);
    chk("miss1_l2_idx", 32'(ri), 32'd1);
    chk("miss1_data", d, 32'h1000_0001);

    // Zero-stall hits
    do_read(21'd0, 5'd1, 6'h04, st, d, rt, ri);
    chk("hit1_stalls", 32'(st), 32'd0);
    chk("hit1_data", d, 32'h1000_0001);
    do_read(21'd0, 5'd1, 6'h3C, st, d, rt, ri);
    chk("hit2_stalls", 32'(st), 32'd0);
    chk("hit2_data", d, 32'h1000_000F);
    do_read(21'd0, 5'd1, 6'h08, st, d, rt, ri);
    chk("hit3_data", d, 32'h1000_0002);
`ifdef L1I_PERF_CNT_EN
    chk("perf_miss", miss_cnt, 32'd1);
    chk("perf_hit", hit_cnt, 32'd4);
`endif

    // Conflict eviction at index 1
    wait_n = 2;
    do_read(21'd1, 5'd1, 6'h00, st, d, rt, ri);
    chk("evict_stalls", 32'(st), 32'd4);
    chk("evict_l2_tag", 32'(rt), 32'd1);
    chk("evict_data", d, 32'h1001_0000);
    wait_n = 3;
    do_read(21'd0, 5'd1, 6'h04, st, d, rt, ri);
    chk("remiss_stalls", 32'(st), 32'd5);
    chk("remiss_data", d, 32'h1000_0001);

    // Flush in idle invalidates every line
    wait_n = 2;
    do_read(21'd5, 5'd0, 6'h00, st, d, rt, ri);
    do_read(21'd7, 5'd2, 6'h04, st, d, rt, ri);
    do_read(21'd5, 5'd0, 6'h00, st, d, rt, ri);
    chk("prefl_hit_stalls", 32'(st), 32'd0);
    flush = 1'b1;
    tick();
    chk("flush_stall", 32'(s_stall), 32'd1);
    flush = 1'b0;
    do_read(21'd5, 5'd0, 6'h00, st, d, rt, ri);
    chk("postfl0_stalls", 32'(st), 32'd4);
    do_read(21'd7, 5'd2, 6'h04, st, d, rt, ri);
    chk("postfl2_stalls", 32'(st), 32'd4);

    // Flush held during a fetch only takes effect once back in idle
    wait_n = 3;
    read = 1'b1; tag = 21'd9; idx = 5'd4; off = 6'd0;
    tick();
    flush = 1'b1; read = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!m_busy) break;
      tick();
    end
    tick();
    chk("held_flush_stall", 32'(s_stall), 32'd1);
    flush = 1'b0;
    do_read(21'd9, 5'd4, 6'h00, st, d, rt, ri);
    chk("held_flush_miss", 32'(st), 32'd5);
    do_read(21'd5, 5'd0, 6'h00, st, d, rt, ri);
    chk("held_flush_miss0", 32'(st), 32'd5);

    // Reset during a fetch aborts it; a stray ready afterwards is ignored
    wait_n = 10;
    read = 1'b1; tag = 21'd2; idx = 5'd6; off = 6'd0;
    tick();
    chk("abort_miss_stall", 32'(s_stall), 32'd1);
    nrst = 1'b1;
    tick();
    chk("abort_req_during", 32'(s_req), 32'd1);
    nrst = 1'b0; read = 1'b0; force_ready = 1'b1;
    tick();
    chk("abort_req_after", 32'(s_req), 32'd0);
    force_ready = 1'b0;
    tick();
    wait_n = 2;
    do_read(21'd2, 5'd6, 6'h00, st, d, rt, ri);
    chk("abort_remiss", 32'(st), 32'd4);

    // Randomised traffic against the model
    rand_wait = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (nrst) nrst = 1'b0;
      else if (r < 2) nrst = 1'b1;
      if (!(read && s_stall && r >= 5)) begin
        read = ($urandom_range(0, 2) != 0);
        tag  = 21'($urandom_range(0, 3));
        idx  = 5'($urandom_range(0, 7));
        off  = 6'($urandom);
      end
      flush = (!m_busy && $urandom_range(0, 29) == 0);
      tick();
    end
    nrst = 1'b0; read = 1'b0; flush = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l1i_cache_ctrl.md
Name: l1i_cache_ctrl

Overview:
- Direct-mapped, read-only L1 instruction cache: 32 lines × 64 B, 21-bit tags.
- Serves as the responder behind the core-side L1 connector. It receives a tag/index/offset plus a read strobe and returns a 32-bit instruction word and a stall.
- On a miss it stalls the core, fetches the full 512-bit line from L2 over a req/ready handshake, fills the line, then completes the read as a hit.

Parameters:
- TAG_W, 21, tag width (address[31:11])
- INDEX_W, 5, index width; line count = 2**INDEX_W = 32
- OFFSET_W, 6, byte offset width; line = 2**OFFSET_W bytes = 512 bits
- WORD_W, 32, returned word width

Ports:
- clk  in  1  clock; all state updates on rising edge
- nrst  in  1  synchronous, active-high reset (1 = reset), sampled on clk rising edge
- read_C_L1I  in  1  core read strobe, held until stall_L1I is low
- tag_C_L1  in  21  request tag
- index_C_L1  in  5  request set index
- offset  in  6  byte offset; [5:2] selects the word, [1:0] ignored
- flush_L1I  in  1  invalidate all lines
- stall_L1I  out  1  core must hold its request
- read_data_L1I_C  out  32  instruction word
- read_L1I_L2  out  1  line fetch request to L2
- tag_L1I_L2  out  21  fetch tag (latched)
- index_L1I_L2  out  5  fetch index (latched)
- ready_L2_L1I  in  1  L2 line valid this cycle
- read_data_L2_L1I  in  512  fill line; word w = bits[32w+31:32w]

Behaviour:
- Storage: data[32][512], tag[32][21], valid[32]. Only valid is reset; data and tag are don't-care after reset.
- hit = read_C_L1I & valid[index_C_L1] & (tag[index_C_L1] == tag_C_L1), evaluated combinationally.
- FSM states: IDLE, ALLOCATE, FILL.
- IDLE, hit:
  - read_data_L1I_C = data[index][offset[5:2]×32 +: 32] in the same cycle.
  - stall_L1I = 0; zero-cycle added latency.
- IDLE, read_C_L1I and no hit:
  - stall_L1I = 1 combinationally.
  - Latch tag and index into the L2 address registers; go to ALLOCATE next edge.
- IDLE, no read: read_data_L1I_C = 0, stall_L1I = 0.
- ALLOCATE:
  - read_L1I_L2 = 1 and stall_L1I = 1; tag_L1I_L2 and index_L1I_L2 stay stable.
  - When ready_L2_L1I = 1 on an edge, capture read_data_L2_L1I into a line buffer and go to FILL.
  - read_L1I_L2 drops the cycle after ready is seen.
  - ready_L2_L1I while not in ALLOCATE is ignored.
- FILL (1 cycle):
  - Write the line buffer, latched tag, and valid = 1 to the latched index; stall_L1I = 1; go to IDLE.
  - The next cycle the held request hits.
  - Miss latency (stall high) = 1 (miss) + N (cycles until ready) + 1 (FILL) cycles; the read completes the cycle after.
- Replacement: the line at the index is overwritten unconditionally (direct-mapped conflict eviction).
- read_C_L1I deasserted during ALLOCATE or FILL: the fill still completes and is not cancellable; stall_L1I stays high until IDLE.
- flush_L1I:
  - Honoured only in IDLE; clears all 32 valid bits on that edge.
  - In the flush cycle stall_L1I = 1 and no miss is started.
  - Ignored in ALLOCATE and FILL; the source must hold it until the controller is in IDLE.
- Reset (nrst = 1):
  - Next edge: state = IDLE, valid = 0, L2 address registers = 0.
  - Outputs read_L1I_L2 = 0, stall_L1I = 0 (absent a read), read_data_L1I_C = 0.
  - A reset during ALLOCATE or FILL aborts: no line is written and the request drops on the next cycle.
- read_data_L1I_C = 0 whenever stall_L1I = 1.

Optional Feature:
- Macro: L1I_PERF_CNT_EN.
- Defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - hit_cnt increments on each IDLE cycle with a hit.
  - miss_cnt increments on each IDLE→ALLOCATE transition; the post-fill hit also counts as a hit.
  - Both cleared by reset; both wrap at 2**32.
- Undefined: no counters and no extra ports.

Test Plan:
- Reset, then read tag=0, index=1, offset=0x04; L2 asserts ready 3 cycles after the request with line word w = 0x1000_0000+w.
  - Required: stall high for 5 cycles, tag_L1I_L2=0, index_L1I_L2=1, then data 0x1000_0001 with stall 0.
- Repeat the same read, then offset=0x3C.
  - Required: zero-stall hits returning 0x1000_0001 and 0x1000_000F.
- Read tag=1, index=1 (address 0x0000_0840).
  - Required: miss and eviction, tag_L1I_L2=1; afterwards tag=0, index=1 misses again.
- Fill indexes 0 and 2, pulse flush_L1I in IDLE.
  - Required: both subsequent reads miss; flush held during ALLOCATE has no effect until IDLE.
- Assert nrst one cycle into ALLOCATE.
  - Required: read_L1I_L2=0 next cycle; a later ready is ignored; the next read of that index misses.
- With L1I_PERF_CNT_EN: 1 miss + 3 hits.
  - Required: miss_cnt=1, hit_cnt=4 (the post-fill hit is included).
